// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one multi-cycle 8x8 multiplier
// between N_REQ requesters. The shared unit is started by holding
// mult_start_o until it reports busy; the result is captured when busy drops.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a stuck transaction
// after TIMEOUT_CYCLES with y_o = 16'hFFFF and an err_o pulse.
module mult_share_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] a_i,
  input  logic [8*N_REQ-1:0] b_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [15:0]        y_o,
  output logic               busy_o,
  output logic               err_o,
  output logic               mult_start_o,
  output logic [7:0]         mult_a_o,
  output logic [7:0]         mult_b_o,
  input  logic               mult_busy_i,
  input  logic [15:0]        mult_y_i
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt, cur, cur_nxt, cur_inc, win;
  logic               found;
  logic [N_REQ-1:0]   ack_nxt, done_nxt;
  logic [15:0]        y_nxt;
  logic               start_nxt;
  logic [7:0]         a_nxt, b_nxt;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
`endif

  // Fold pointer+offset back into 0..N_REQ-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    if (v >= N_REQ) return IDX_W'(v - N_REQ);
    return IDX_W'(v);
  endfunction

  assign cur_inc = (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + IDX_W'(1);

  // Round-robin search: first set request at or above the pointer, with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[wrap_idx(32'(ptr) + i)]) begin
        found = 1'b1;
        win   = wrap_idx(32'(ptr) + i);
      end
    end
  end

  // Next-state and next-output logic for the start/busy-wait/capture sequence.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cur_nxt   = cur;
    ack_nxt   = '0;
    done_nxt  = '0;
    y_nxt     = y_o;
    start_nxt = mult_start_o;
    a_nxt     = mult_a_o;
    b_nxt     = mult_b_o;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          a_nxt        = a_i[{win, 3'b000} +: 8];
          b_nxt        = b_i[{win, 3'b000} +: 8];
          ack_nxt[win] = 1'b1;
          start_nxt    = 1'b1;
          cur_nxt      = win;
          state_nxt    = START;
`ifdef MULT_ARB_TIMEOUT_EN
          cnt_nxt      = '0;
`endif
        end
      end
      START: begin
        if (mult_busy_i) begin
          start_nxt = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        start_nxt = 1'b0;
        if (!mult_busy_i) begin
          y_nxt         = mult_y_i;
          done_nxt[cur] = 1'b1;
          ptr_nxt       = cur_inc;
          state_nxt     = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: normal completion in RUN wins over a same-cycle timeout.
    if (state == START || (state == RUN && mult_busy_i)) begin
      cnt_nxt = cnt + CNT_W'(1);
      if (cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
        start_nxt     = 1'b0;
        y_nxt         = 16'hFFFF;
        done_nxt      = '0;
        done_nxt[cur] = 1'b1;
        err_nxt       = 1'b1;
        ptr_nxt       = cur_inc;
        state_nxt     = DONE;
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      cur          <= '0;
      ack_o        <= '0;
      done_o       <= '0;
      y_o          <= '0;
      busy_o       <= 1'b0;
      mult_start_o <= 1'b0;
      mult_a_o     <= '0;
      mult_b_o     <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      cur          <= cur_nxt;
      ack_o        <= ack_nxt;
      done_o       <= done_nxt;
      y_o          <= y_nxt;
      busy_o       <= (state_nxt != IDLE);
      mult_start_o <= start_nxt;
      mult_a_o     <= a_nxt;
      mult_b_o     <= b_nxt;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      err_o <= err_nxt;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a behavioural 16-cycle shared multiplier.
// Watchdog sequence only runs when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_share_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 64;
  localparam int unsigned LAT = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_i;
  logic [8*N-1:0] a_i, b_i;
  logic [N-1:0]  ack_o, done_o;
  logic [15:0]   y_o;
  logic          busy_o, err_o, mult_start_o;
  logic [7:0]    mult_a_o, mult_b_o;
  logic          mult_busy_i;
  logic [15:0]   mult_y_i;

  int n_tests = 0;
  int n_fail  = 0;
  int dcnt[N];

  mult_share_arbiter #(.N_REQ(N), .IDX_W(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .ack_o(ack_o), .done_o(done_o), .y_o(y_o), .busy_o(busy_o), .err_o(err_o),
    .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .mult_busy_i(mult_busy_i), .mult_y_i(mult_y_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural shared multiplier: start loads operands, busy for LAT cycles.
  logic [7:0]  ma = '0, mb = '0;
  int          mcnt = 0;
  logic        mbusy = 1'b0;
  logic [15:0] my = '0;
  logic        force_busy = 1'b0;
  always @(posedge clk_i) begin
    if (mult_start_o) begin
      ma <= mult_a_o; mb <= mult_b_o; mcnt <= LAT; mbusy <= 1'b1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mbusy <= 1'b0;
        my    <= 16'(ma) * 16'(mb);
      end
    end
  end
  assign mult_busy_i = force_busy | mbusy;
  assign mult_y_i    = my;

  always @(negedge clk_i)
    for (int k = 0; k < N; k++) if (done_o[k]) dcnt[k]++;

  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] a;
    logic [8*N-1:0] b;
    logic [N-1:0]   exp_ack;
    logic [15:0]    exp_y;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output logic [N-1:0] got, output int lat);
    got = '0; lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(negedge clk_i);
      if (ack_o != '0) begin got = ack_o; lat = i; end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 200 cycles");
    end
  endtask

  task automatic wait_done(input int budget, output logic [N-1:0] d,
                           output logic [15:0] y, output logic e, output int stray);
    bit seen = 1'b0;
    d = '0; y = '0; e = 1'b0; stray = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (ack_o != '0) stray++;
      if (done_o != '0) begin seen = 1'b1; d = done_o; y = y_o; e = err_o; end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  logic [N-1:0] got, d;
  logic [15:0]  y;
  logic         e;
  int           lat, stray, d1, d2;
  logic [15:0]  rr_y[5];

  initial begin
    vecs[0] = '{4'b0001, 32'h0000_000C, 32'h0000_000A, 4'b0001, 16'd120};
    vecs[1] = '{4'b1000, 32'hFF00_0000, 32'hFF00_0000, 4'b1000, 16'hFE01};
    vecs[2] = '{4'b0110, 32'h00C8_0300, 32'h0002_0700, 4'b0010, 16'd21};
    vecs[3] = '{4'b0101, 32'h0009_0011, 32'h0009_0022, 4'b0100, 16'd81};
    vecs[4] = '{4'b0011, 32'h0000_0500, 32'h0000_4D00, 4'b0001, 16'd0};
    vecs[5] = '{4'b1000, 32'h8000_0000, 32'h0200_0000, 4'b1000, 16'd256};
    rr_y = '{16'd5, 16'd12, 16'd21, 16'd32, 16'd5};

    rst_i = 1'b1; req_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_y", 32'(y_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_start", 32'(mult_start_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table: single transactions, losers drop their request before ack.
    for (int v = 0; v < 6; v++) begin
      req_i = vecs[v].req; a_i = vecs[v].a; b_i = vecs[v].b;
      wait_ack(got, lat);
      chk($sformatf("v%0d_ack", v), 32'(got), 32'(vecs[v].exp_ack));
      chk($sformatf("v%0d_lat", v), 32'(lat), 0);
      req_i = '0;
      wait_done(100, d, y, e, stray);
      chk($sformatf("v%0d_done", v), 32'(d), 32'(vecs[v].exp_ack));
      chk($sformatf("v%0d_y", v), 32'(y), 32'(vecs[v].exp_y));
      chk($sformatf("v%0d_err", v), 32'(e), 0);
      chk($sformatf("v%0d_stray_ack", v), 32'(stray), 0);
      @(negedge clk_i);
      chk($sformatf("v%0d_idle", v), 32'(busy_o), 0);
    end

    // Requesters 1 and 2 together with pointer 0: 1 then 2, one done each.
    d1 = dcnt[1]; d2 = dcnt[2];
    a_i = 32'h00C8_0300; b_i = 32'h0002_0700; req_i = 4'b0110;
    wait_ack(got, lat);
    chk("pair_ack1", 32'(got), 32'b0010);
    req_i = 4'b0100;
    wait_done(100, d, y, e, stray);
    chk("pair_done1", 32'(d), 32'b0010);
    chk("pair_y1", 32'(y), 21);
    wait_ack(got, lat);
    chk("pair_ack2", 32'(got), 32'b0100);
    req_i = '0;
    wait_done(100, d, y, e, stray);
    chk("pair_done2", 32'(d), 32'b0100);
    chk("pair_y2", 32'(y), 400);
    repeat (3) @(negedge clk_i);
    chk("pair_cnt1", 32'(dcnt[1] - d1), 1);
    chk("pair_cnt2", 32'(dcnt[2] - d2), 1);

    // Reset mid-RUN: outputs clear asynchronously, no done, pointer back to 0.
    d1 = dcnt[0];
    a_i = 32'h0000_0005; b_i = 32'h0000_0006; req_i = 4'b0001;
    wait_ack(got, lat);
    chk("rr_pre_ack", 32'(got), 32'b0001);
    req_i = '0;
    repeat (6) @(negedge clk_i);
    chk("run_busy", 32'(busy_o), 1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_y", 32'(y_o), 0);
    chk("arst_a", 32'(mult_a_o), 0);
    chk("arst_b", 32'(mult_b_o), 0);
    chk("arst_start", 32'(mult_start_o), 0);
    chk("arst_ack_done", 32'({ack_o, done_o}), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("arst_no_done", 32'(dcnt[0] - d1), 0);

    // All four held: grants 0,1,2,3,0 from the reset pointer.
    a_i = {8'd4, 8'd3, 8'd2, 8'd1}; b_i = {8'd8, 8'd7, 8'd6, 8'd5};
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(got, lat);
      chk($sformatf("rr%0d_ack", g), 32'(got), 32'(1) << (g % 4));
      if (g == 4) req_i = '0;
      wait_done(100, d, y, e, stray);
      chk($sformatf("rr%0d_done", g), 32'(d), 32'(1) << (g % 4));
      chk($sformatf("rr%0d_y", g), 32'(y), 32'(rr_y[g]));
      chk($sformatf("rr%0d_stray_ack", g), 32'(stray), 0);
    end
    repeat (3) @(negedge clk_i);

`ifdef MULT_ARB_TIMEOUT_EN
    // Stuck multiplier: watchdog returns 16'hFFFF with err.
    force_busy = 1'b1;
    a_i = 32'h0000_0003; b_i = 32'h0000_0003; req_i = 4'b0001;
    wait_ack(got, lat);
    chk("tmo_ack", 32'(got), 32'b0001);
    req_i = '0;
    wait_done(TMO + 20, d, y, e, stray);
    chk("tmo_done", 32'(d), 32'b0001);
    chk("tmo_y", 32'(y), 32'hFFFF);
    chk("tmo_err", 32'(e), 1);
    @(negedge clk_i);
    chk("tmo_err_clear", 32'(err_o), 0);
    chk("tmo_idle", 32'(busy_o), 0);
    force_busy = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
